// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: state codes,
// opcode/funct values, ALU control codes, mux select encodings, and the
// per-state control word.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    FETCH   = 4'd1,
    DECODE  = 4'd2,
    MEMADR  = 4'd3,
    MEMRD   = 4'd4,
    MEMWB   = 4'd5,
    MEMWR   = 4'd6,
    EXEC    = 4'd7,
    ALUWB   = 4'd8,
    BRANCH  = 4'd9,
    ADDIEX  = 4'd10,
    ADDIWB  = 4'd11,
    JUMP    = 4'd12,
    ILLEGAL = 4'd13
  } state_t;

  // opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU control codes
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU operation class handed to the decoder; NONE drives alu_ctl to 0
  localparam logic [1:0] AOP_NONE  = 2'b00;
  localparam logic [1:0] AOP_ADD   = 2'b01;
  localparam logic [1:0] AOP_SUB   = 2'b10;
  localparam logic [1:0] AOP_FUNCT = 2'b11;

  // alu_src_b selects
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // pc_src selects
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       illegal_op;
  } ctl_t;

  // Control word asserted while the FSM sits in state s; anything not
  // listed for a state stays 0.
  function automatic ctl_t ctl_of(state_t s);
    ctl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = AOP_ADD;
        c.pc_src    = PCSRC_ALU;
      end
      DECODE: begin
        c.alu_src_b = SRCB_IMMSH;
        c.alu_op    = AOP_ADD;
      end
      MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = AOP_ADD;
      end
      MEMRD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.instr_done = 1'b1;
      end
      MEMWR: begin
        c.mem_write  = 1'b1;
        c.i_or_d     = 1'b1;
        c.instr_done = 1'b1;
      end
      EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_B;
        c.alu_op    = AOP_FUNCT;
      end
      ALUWB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = 1'b1;
        c.instr_done = 1'b1;
      end
      BRANCH: begin
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = SRCB_B;
        c.alu_op     = AOP_SUB;
        c.branch     = 1'b1;
        c.pc_src     = PCSRC_ALUOUT;
        c.instr_done = 1'b1;
      end
      ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = AOP_ADD;
      end
      ADDIWB: begin
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      JUMP: begin
        c.pc_write   = 1'b1;
        c.pc_src     = PCSRC_JUMP;
        c.instr_done = 1'b1;
      end
      ILLEGAL: begin
        c.illegal_op = 1'b1;
        c.instr_done = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// ALU control decoder: maps the FSM's ALU operation class plus the
// instruction funct field onto the ALU control code. Unknown funct
// values fall back to add.
module mips_alu_decoder #(
  parameter int OP_W     = 6,
  parameter int ALUCTL_W = 3
) (
  input  logic [1:0]          alu_op,
  input  logic [OP_W-1:0]     funct,
  output logic [ALUCTL_W-1:0] alu_ctl
);
  import mips_ctrl_pkg::*;

  // pick the ALU code from the op class, consulting funct for R-type
  always_comb begin
    alu_ctl = '0;
    case (alu_op)
      AOP_ADD: alu_ctl = ALUCTL_W'(ALU_ADD);
      AOP_SUB: alu_ctl = ALUCTL_W'(ALU_SUB);
      AOP_FUNCT: begin
        case (funct)
          OP_W'(FN_ADD): alu_ctl = ALUCTL_W'(ALU_ADD);
          OP_W'(FN_SUB): alu_ctl = ALUCTL_W'(ALU_SUB);
          OP_W'(FN_AND): alu_ctl = ALUCTL_W'(ALU_AND);
          OP_W'(FN_OR):  alu_ctl = ALUCTL_W'(ALU_OR);
          OP_W'(FN_SLT): alu_ctl = ALUCTL_W'(ALU_SLT);
          default:       alu_ctl = ALUCTL_W'(ALU_ADD);
        endcase
      end
      default: alu_ctl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM. Moore machine: the control word is
// registered from the next state so every strobe leaves a flop; pc_en
// folds in the live ALU zero flag and alu_ctl decodes the live funct.
// Optional feature macro: MIPS_MEM_WAIT_EN -- FETCH/MEMRD/MEMWR hold until
// mem_ready, and the FETCH register updates fire only in the ready cycle.
module mips_multicycle_ctrl #(
  parameter int OP_W     = 6,
  parameter int ALUCTL_W = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OP_W-1:0]     opcode,
  input  logic [OP_W-1:0]     funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_en,
  output logic                ir_write,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          pc_src,
  output logic [ALUCTL_W-1:0] alu_ctl,
  output logic                instr_done,
  output logic                illegal_op,
  output logic [3:0]          state
);
  import mips_ctrl_pkg::*;

  state_t st, ns;
  ctl_t   ctl;
  logic   mem_hold;

`ifdef MIPS_MEM_WAIT_EN
  assign mem_hold = ~mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_hold         = 1'b0;
`endif

  // next-state selection; opcode only matters in DECODE and MEMADR
  always_comb begin
    ns = st;
    case (st)
      IDLE:   ns = FETCH;
      FETCH:  ns = mem_hold ? FETCH : DECODE;
      DECODE: begin
        if (opcode == OP_W'(OP_LW) || opcode == OP_W'(OP_SW)) ns = MEMADR;
        else if (opcode == OP_W'(OP_RTYPE))                   ns = EXEC;
        else if (opcode == OP_W'(OP_BEQ))                     ns = BRANCH;
        else if (opcode == OP_W'(OP_ADDI))                    ns = ADDIEX;
        else if (opcode == OP_W'(OP_J))                       ns = JUMP;
        else                                                  ns = ILLEGAL;
      end
      MEMADR:  ns = (opcode == OP_W'(OP_SW)) ? MEMWR : MEMRD;
      MEMRD:   ns = mem_hold ? MEMRD : MEMWB;
      MEMWB:   ns = FETCH;
      MEMWR:   ns = mem_hold ? MEMWR : FETCH;
      EXEC:    ns = ALUWB;
      ALUWB:   ns = FETCH;
      BRANCH:  ns = FETCH;
      ADDIEX:  ns = ADDIWB;
      ADDIWB:  ns = FETCH;
      JUMP:    ns = FETCH;
      ILLEGAL: ns = FETCH;
      default: ns = IDLE;
    endcase
  end

  // state and registered control word; reset clears both at once so no
  // strobe outlives an aborted instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st  <= IDLE;
      ctl <= '0;
    end else begin
      st  <= ns;
      ctl <= ctl_of(ns);
    end
  end

  // While memory stalls, the registers fed by FETCH and the MEMWR
  // completion pulse must wait for the ready cycle; strobes stay up.
  logic stall_fetch, stall_wr;
  assign stall_fetch = ctl.ir_write  & mem_hold;
  assign stall_wr    = ctl.mem_write & mem_hold;

  assign pc_en      = (ctl.pc_write & ~stall_fetch) | (ctl.branch & zero);
  assign ir_write   = ctl.ir_write & ~stall_fetch;
  assign i_or_d     = ctl.i_or_d;
  assign mem_read   = ctl.mem_read;
  assign mem_write  = ctl.mem_write;
  assign mem_to_reg = ctl.mem_to_reg;
  assign reg_dst    = ctl.reg_dst;
  assign reg_write  = ctl.reg_write;
  assign alu_src_a  = ctl.alu_src_a;
  assign alu_src_b  = ctl.alu_src_b;
  assign pc_src     = ctl.pc_src;
  assign instr_done = ctl.instr_done & ~stall_wr;
  assign illegal_op = ctl.illegal_op;
  assign state      = st;

  mips_alu_decoder #(.OP_W(OP_W), .ALUCTL_W(ALUCTL_W)) u_aludec (
    .alu_op  (ctl.alu_op),
    .funct   (funct),
    .alu_ctl (alu_ctl)
  );

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: each instruction class expands into its
// list of phases, and every cycle the full output vector is compared
// against the control table for that phase. Opcode/funct/zero/mem_ready are
// randomized wherever they should not matter.
module tb_mips_multicycle_ctrl;

`ifdef MIPS_MEM_WAIT_EN
  localparam bit WAIT_MODE = 1'b1;
`else
  localparam bit WAIT_MODE = 1'b0;
`endif

  // phase numbers = state codes in the order the states are listed
  localparam int P_FETCH = 1, P_DECODE = 2, P_MEMADR = 3, P_MEMRD = 4, P_MEMWB = 5,
                 P_MEMWR = 6, P_EXEC = 7, P_ALUWB = 8, P_BRANCH = 9, P_ADDIEX = 10,
                 P_ADDIWB = 11, P_JUMP = 12, P_ILLEGAL = 13;

  logic       clk, rst_n, zero, mem_ready;
  logic [5:0] opcode, funct;
  logic       pc_en, ir_write, i_or_d, mem_read, mem_write, mem_to_reg;
  logic       reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_ctl;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  typedef int phq_t[$];

  mips_multicycle_ctrl #(.OP_W(6), .ALUCTL_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .ir_write(ir_write), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .reg_dst(reg_dst), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_ctl(alu_ctl),
    .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [21:0] obs();
    return {pc_en, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_dst,
            reg_write, alu_src_a, alu_src_b, pc_src, alu_ctl, instr_done,
            illegal_op, state};
  endfunction

  function automatic logic [2:0] alu_of(logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // expected outputs for one cycle spent in phase ph
  function automatic logic [21:0] exp_vec(int ph, logic z, logic [5:0] fn, logic rdy);
    logic pcw, irw, iod, mr, mw, m2r, rd, rw, sa, br, dn, ill, stall;
    logic [1:0] sb, ps;
    logic [2:0] ac;
    {pcw, irw, iod, mr, mw, m2r, rd, rw, sa, br, dn, ill} = '0;
    sb = 2'b00; ps = 2'b00; ac = 3'b000;
    stall = WAIT_MODE && !rdy;
    case (ph)
      P_FETCH:   begin mr = 1; irw = !stall; pcw = !stall; sb = 2'b01; ac = 3'b010; end
      P_DECODE:  begin sb = 2'b11; ac = 3'b010; end
      P_MEMADR:  begin sa = 1; sb = 2'b10; ac = 3'b010; end
      P_MEMRD:   begin mr = 1; iod = 1; end
      P_MEMWB:   begin rw = 1; m2r = 1; dn = 1; end
      P_MEMWR:   begin mw = 1; iod = 1; dn = !stall; end
      P_EXEC:    begin sa = 1; ac = alu_of(fn); end
      P_ALUWB:   begin rw = 1; rd = 1; dn = 1; end
      P_BRANCH:  begin sa = 1; ac = 3'b110; br = 1; ps = 2'b01; dn = 1; end
      P_ADDIEX:  begin sa = 1; sb = 2'b10; ac = 3'b010; end
      P_ADDIWB:  begin rw = 1; dn = 1; end
      P_JUMP:    begin pcw = 1; ps = 2'b10; dn = 1; end
      P_ILLEGAL: begin ill = 1; dn = 1; end
      default: ;
    endcase
    return {pcw | (br & z), irw, iod, mr, mw, m2r, rd, rw, sa, sb, ps, ac, dn, ill, 4'(ph)};
  endfunction

  // phase sequence of an instruction, FETCH through its last state
  function automatic phq_t phases_for(logic [5:0] op);
    phq_t q;
    q = {};
    q.push_back(P_FETCH);
    q.push_back(P_DECODE);
    case (op)
      6'b100011: begin q.push_back(P_MEMADR); q.push_back(P_MEMRD); q.push_back(P_MEMWB); end
      6'b101011: begin q.push_back(P_MEMADR); q.push_back(P_MEMWR); end
      6'b000000: begin q.push_back(P_EXEC); q.push_back(P_ALUWB); end
      6'b000100: q.push_back(P_BRANCH);
      6'b001000: begin q.push_back(P_ADDIEX); q.push_back(P_ADDIWB); end
      6'b000010: q.push_back(P_JUMP);
      default:   q.push_back(P_ILLEGAL);
    endcase
    return q;
  endfunction

  task automatic chk(input string tag, input logic [21:0] o, input logic [21:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  // Runs one instruction starting #1 after the edge that entered FETCH.
  // zsel<0 randomizes zero; low_n forces that many not-ready FETCH cycles.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int zsel, input int low_n);
    phq_t ph;
    int   k;
    logic z, rdy, memph;
    ph = phases_for(op);
    foreach (ph[i]) begin
      k = 0;
      memph = (ph[i] == P_FETCH || ph[i] == P_MEMRD || ph[i] == P_MEMWR);
      do begin
        opcode = (ph[i] == P_DECODE || ph[i] == P_MEMADR) ? op : 6'($urandom);
        funct  = (ph[i] == P_EXEC) ? fn : 6'($urandom);
        z      = (zsel < 0) ? 1'($urandom) : 1'(zsel);
        if (WAIT_MODE && memph)
          rdy = (ph[i] == P_FETCH && low_n > 0) ? (k >= low_n)
                                                 : ((k >= 2) ? 1'b1 : 1'($urandom));
        else
          rdy = 1'($urandom);
        zero = z;
        mem_ready = rdy;
        @(negedge clk);
        chk($sformatf("op=%b ph=%0d wait=%0d", op, ph[i], k), obs(), exp_vec(ph[i], z, fn, rdy));
        @(posedge clk); #1;
        k++;
      end while (WAIT_MODE && memph && !rdy);
    end
  endtask

  initial begin
    logic [5:0] ops [7];
    logic [5:0] fns [6];
    logic [5:0] op, fn;
    ops[0] = 6'b100011; ops[1] = 6'b101011; ops[2] = 6'b000000; ops[3] = 6'b000100;
    ops[4] = 6'b001000; ops[5] = 6'b000010; ops[6] = 6'b111111;
    fns[0] = 6'b100000; fns[1] = 6'b100010; fns[2] = 6'b100100;
    fns[3] = 6'b100101; fns[4] = 6'b101010; fns[5] = 6'b000111;

    rst_n = 1'b0; opcode = 6'd0; funct = 6'd0; zero = 1'b1; mem_ready = 1'b1;
    #2 chk("reset", obs(), 22'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle", obs(), 22'd0);
    @(posedge clk); #1;

    // lw, then R-type slt
    run_instr(6'b100011, 6'd0, -1, 0);
    run_instr(6'b000000, 6'b101010, -1, 0);
    // beq taken / not taken
    run_instr(6'b000100, 6'd0, 1, 0);
    run_instr(6'b000100, 6'd0, 0, 0);
    // illegal, sw, addi, j
    run_instr(6'b111111, 6'd0, -1, 0);
    run_instr(6'b101011, 6'd0, -1, 0);
    run_instr(6'b001000, 6'd0, -1, 0);
    run_instr(6'b000010, 6'd0, -1, 0);
    // three not-ready FETCH cycles (only stalls when the wait feature is built)
    run_instr(6'b000000, 6'b100010, -1, 3);

    // reset in the middle of a lw, while sitting in MEMRD
    mem_ready = 1'b1; zero = 1'b1;
    opcode = 6'b100011;
    repeat (3) begin @(posedge clk); #1; end
    chk("pre-reset memrd", obs(), exp_vec(P_MEMRD, 1'b1, 6'd0, 1'b1));
    rst_n = 1'b0;
    #1 chk("reset mid-memrd", obs(), 22'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("idle after abort", obs(), 22'd0);
    @(posedge clk); #1;

    // random instruction mix
    for (int n = 0; n < 60; n++) begin
      op = ops[$urandom_range(6)];
      if (op == 6'b111111) op = 6'($urandom);
      fn = fns[$urandom_range(5)];
      if (fn == 6'b000111) fn = 6'($urandom);
      run_instr(op, fn, -1, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
